// File: rtl/cond_pkg.sv
// Shared definitions for the condition-check / flag-writeback stage.
//   cond_e   : ARM 4-bit condition field encodings (EQ..AL, NV = 4'hF)
//   FLAG_*   : bit positions inside the {N,Z,C,V} flag vector
//   FW_*     : bit positions inside the 2-bit flag write mask
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0,
    NE = 4'h1,
    CS = 4'h2,
    CC = 4'h3,
    MI = 4'h4,
    PL = 4'h5,
    VS = 4'h6,
    VC = 4'h7,
    HI = 4'h8,
    LS = 4'h9,
    GE = 4'hA,
    LT = 4'hB,
    GT = 4'hC,
    LE = 4'hD,
    AL = 4'hE,
    NV = 4'hF
  } cond_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam int unsigned FW_NZ = 1;
  localparam int unsigned FW_CV = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition evaluator.
// Ports:
//   cond   in  4  condition field
//   flags  in  4  {N,Z,C,V}
//   condex out 1  condition passes
//   undef  out 1  condition field was 4'hF (never executes)
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       condex,
  output logic       undef
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    condex = 1'b0;
    undef  = 1'b0;
    unique case (cond_e'(cond))
      EQ: condex = z;
      NE: condex = !z;
      CS: condex = c;
      CC: condex = !c;
      MI: condex = n;
      PL: condex = !n;
      VS: condex = v;
      VC: condex = !v;
      HI: condex = c && !z;
      LS: condex = !c || z;
      GE: condex = (n == v);
      LT: condex = (n != v);
      GT: condex = !z && (n == v);
      LE: condex = z || (n != v);
      AL: condex = 1'b1;
      NV: undef  = 1'b1;
      default: condex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Condition-check and NZCV flag-writeback stage behind the ALU.
// Holds the architectural flag register, evaluates the instruction's condition against it
// (pre-update value) and issues gated reg/mem/PC write enables through a one-entry
// valid/ready output register.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          upstream handshake
//   in_cond, in_flagw          condition field, flag write mask ([1]=N,Z [0]=C,V)
//   in_aluflags                {N,Z,C,V} from the ALU
//   in_regw/in_memw/in_pcs     write requests
//   out_valid/out_ready        downstream handshake
//   out_regw/out_memw/out_pcs  requests gated by condex
//   out_condex, out_undef      registered condition result / cond==4'hF
//   flags                      current NZCV register
// Optional build macro COND_STATS_EN adds saturating counters exec_cnt and squash_cnt.
module cond_unit
  import cond_pkg::*;
#(
  parameter logic [3:0]  FLAGS_RST = 4'b0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_cond,
  input  logic [1:0]       in_flagw,
  input  logic [3:0]       in_aluflags,
  input  logic             in_regw,
  input  logic             in_memw,
  input  logic             in_pcs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_regw,
  output logic             out_memw,
  output logic             out_pcs,
  output logic             out_condex,
  output logic             out_undef,
  output logic [3:0]       flags
`ifdef COND_STATS_EN
  ,
  output logic [CNT_W-1:0] exec_cnt,
  output logic [CNT_W-1:0] squash_cnt
`endif
);

  logic [3:0] flags_q, flags_d;
  logic       out_valid_q, out_valid_d;
  logic       out_regw_q, out_memw_q, out_pcs_q, out_condex_q, out_undef_q;
  logic       accept;
  logic       condex, undef;

  // Condition always reads the committed flags, never the incoming ALU flags.
  cond_eval u_cond_eval (
    .cond   (in_cond),
    .flags  (flags_q),
    .condex (condex),
    .undef  (undef)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    flags_d = flags_q;
    if (accept && condex) begin
      if (in_flagw[FW_NZ]) begin
        flags_d[FLAG_N] = in_aluflags[FLAG_N];
        flags_d[FLAG_Z] = in_aluflags[FLAG_Z];
      end
      if (in_flagw[FW_CV]) begin
        flags_d[FLAG_C] = in_aluflags[FLAG_C];
        flags_d[FLAG_V] = in_aluflags[FLAG_V];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (accept) begin
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q      <= FLAGS_RST;
      out_valid_q  <= 1'b0;
      out_regw_q   <= 1'b0;
      out_memw_q   <= 1'b0;
      out_pcs_q    <= 1'b0;
      out_condex_q <= 1'b0;
      out_undef_q  <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      // Fields only change on accept, so they hold steady under backpressure.
      if (accept) begin
        out_regw_q   <= in_regw && condex;
        out_memw_q   <= in_memw && condex;
        out_pcs_q    <= in_pcs && condex;
        out_condex_q <= condex;
        out_undef_q  <= undef;
      end
    end
  end

  assign flags      = flags_q;
  assign out_valid  = out_valid_q;
  assign out_regw   = out_regw_q;
  assign out_memw   = out_memw_q;
  assign out_pcs    = out_pcs_q;
  assign out_condex = out_condex_q;
  assign out_undef  = out_undef_q;

`ifdef COND_STATS_EN
  logic [CNT_W-1:0] exec_cnt_q, squash_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exec_cnt_q   <= '0;
      squash_cnt_q <= '0;
    end else if (accept) begin
      if (condex) begin
        if (exec_cnt_q != {CNT_W{1'b1}}) exec_cnt_q <= exec_cnt_q + 1'b1;
      end else begin
        if (squash_cnt_q != {CNT_W{1'b1}}) squash_cnt_q <= squash_cnt_q + 1'b1;
      end
    end
  end

  assign exec_cnt   = exec_cnt_q;
  assign squash_cnt = squash_cnt_q;
`else
  // CNT_W only sizes the optional counters.
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed steps plus a short random burst, with an
// output scoreboard fed at accept time and drained when the DUT presents entries.
module tb_cond_unit;
  import cond_pkg::*;

  localparam int unsigned CW = 2;

  typedef struct packed {
    logic regw;
    logic memw;
    logic pcs;
    logic condex;
    logic undef;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_cond;
  logic [1:0]    in_flagw;
  logic [3:0]    in_aluflags;
  logic          in_regw, in_memw, in_pcs;
  logic          out_valid;
  logic          out_ready;
  logic          out_regw, out_memw, out_pcs, out_condex, out_undef;
  logic [3:0]    flags;
`ifdef COND_STATS_EN
  logic [CW-1:0] exec_cnt, squash_cnt;
`endif

  always #5 clk = ~clk;

  cond_unit #(
    .FLAGS_RST (4'b0000),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_cond     (in_cond),
    .in_flagw    (in_flagw),
    .in_aluflags (in_aluflags),
    .in_regw     (in_regw),
    .in_memw     (in_memw),
    .in_pcs      (in_pcs),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_regw    (out_regw),
    .out_memw    (out_memw),
    .out_pcs     (out_pcs),
    .out_condex  (out_condex),
    .out_undef   (out_undef),
    .flags       (flags)
`ifdef COND_STATS_EN
    ,
    .exec_cnt    (exec_cnt),
    .squash_cnt  (squash_cnt)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  logic          mv;
  logic [3:0]    mflags;
  logic [CW-1:0] m_exec, m_squash;
  ent_t          sb[$];

  // Returns {condex, undef} straight from the ARM condition table.
  function automatic logic [1:0] ref_eval(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, cx;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    cx = 1'b0;
    case (cond)
      4'd0:  cx = z;
      4'd1:  cx = !z;
      4'd2:  cx = c;
      4'd3:  cx = !c;
      4'd4:  cx = n;
      4'd5:  cx = !n;
      4'd6:  cx = v;
      4'd7:  cx = !v;
      4'd8:  cx = c & !z;
      4'd9:  cx = !c | z;
      4'd10: cx = (n == v);
      4'd11: cx = (n != v);
      4'd12: cx = !z & (n == v);
      4'd13: cx = z | (n != v);
      4'd14: cx = 1'b1;
      default: return 2'b01;
    endcase
    return {cx, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [3:0] cond, input logic [1:0] fw,
                     input logic [3:0] alu, input logic rw, input logic mw, input logic pc);
    in_valid    = v;
    in_cond     = cond;
    in_flagw    = fw;
    in_aluflags = alu;
    in_regw     = rw;
    in_memw     = mw;
    in_pcs      = pc;
  endtask

  task automatic model_reset();
    mv       = 1'b0;
    mflags   = 4'b0000;
    m_exec   = '0;
    m_squash = '0;
    sb.delete();
  endtask

  // One clock: check outputs at the negedge, advance the model, check state after posedge.
  task automatic step();
    logic [1:0] r;
    logic       acc;
    ent_t       e;
    @(negedge clk);
    chk("in_ready", 8'(in_ready), 8'(!mv || out_ready));
    chk("out_valid", 8'(out_valid), 8'(mv));
    if (mv) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 8'(1), 8'(0));
      end else begin
        chk("out_fields", 8'({out_regw, out_memw, out_pcs, out_condex, out_undef}),
            8'(sb[0]));
        if (out_ready) void'(sb.pop_front());
      end
    end
    acc = in_valid && (!mv || out_ready);
    if (acc) begin
      r = ref_eval(in_cond, mflags);
      e.regw   = in_regw & r[1];
      e.memw   = in_memw & r[1];
      e.pcs    = in_pcs & r[1];
      e.condex = r[1];
      e.undef  = r[0];
      sb.push_back(e);
      mv = 1'b1;
      if (r[1]) begin
        if (in_flagw[1]) mflags[3:2] = in_aluflags[3:2];
        if (in_flagw[0]) mflags[1:0] = in_aluflags[1:0];
        if (m_exec != {CW{1'b1}}) m_exec = m_exec + 1'b1;
      end else begin
        if (m_squash != {CW{1'b1}}) m_squash = m_squash + 1'b1;
      end
    end else if (mv && out_ready) begin
      mv = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("flags", 8'(flags), 8'(mflags));
`ifdef COND_STATS_EN
    chk("exec_cnt", 8'(exec_cnt), 8'(m_exec));
    chk("squash_cnt", 8'(squash_cnt), 8'(m_squash));
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drv(1'b0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #1;
    chk("rst_flags", 8'(flags), 8'h0);
    chk("rst_out_valid", 8'(out_valid), 8'h0);
    chk("rst_in_ready", 8'(in_ready), 8'h1);
    chk("rst_fields", 8'({out_regw, out_memw, out_pcs, out_condex, out_undef}), 8'h0);
`ifdef COND_STATS_EN
    chk("rst_exec", 8'(exec_cnt), 8'h0);
    chk("rst_squash", 8'(squash_cnt), 8'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    out_ready = 1'b1;
    drv(1'b0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    do_reset();

    // Idle after reset.
    repeat (3) step();

    // Squashed EQ must not write flags; AL then does.
    drv(1'b1, EQ, 2'b11, 4'b0100, 1'b1, 1'b0, 1'b0);
    step();
    drv(1'b1, AL, 2'b11, 4'b0100, 1'b1, 1'b0, 1'b0);
    step();
    chk("al_flags", 8'(flags), 8'b0100);
    drv(1'b0, AL, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    step();

    // Back-to-back: HI sees C written by the previous AL.
    drv(1'b1, AL, 2'b11, 4'b0010, 1'b0, 1'b1, 1'b0);
    step();
    drv(1'b1, HI, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b1);
    step();
    drv(1'b1, LS, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b1);
    step();
    drv(1'b0, AL, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    step();

    // Backpressure for 3 cycles, then release with a waiting instruction.
    out_ready = 1'b0;
    drv(1'b1, AL, 2'b11, 4'b1001, 1'b1, 1'b0, 1'b1);
    step();
    drv(1'b1, AL, 2'b11, 4'b0110, 1'b0, 1'b1, 1'b0);
    repeat (3) step();
    chk("bp_in_ready", 8'(in_ready), 8'h0);
    out_ready = 1'b1;
    step();
    drv(1'b0, AL, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    step();

    // Partial mask and undefined condition.
    drv(1'b1, AL, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b0);
    step();
    drv(1'b1, AL, 2'b01, 4'b0000, 1'b0, 1'b0, 1'b0);
    step();
    chk("partial_flags", 8'(flags), 8'b1100);
    drv(1'b1, NV, 2'b11, 4'b0000, 1'b1, 1'b1, 1'b1);
    step();
    drv(1'b0, AL, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk("undef_flags", 8'(flags), 8'b1100);

    // Random burst over all conditions, masks and backpressure patterns.
    for (int i = 0; i < 60; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      drv(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
          4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom));
      step();
    end
    out_ready = 1'b1;
    drv(1'b0, AL, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) step();

    // Reset while an entry is held and flags are non-zero.
    drv(1'b1, AL, 2'b11, 4'b1010, 1'b1, 1'b1, 1'b1);
    step();
    out_ready = 1'b0;
    drv(1'b1, AL, 2'b11, 4'b0101, 1'b1, 1'b0, 1'b0);
    step();
    do_reset();
    out_ready = 1'b1;
    step();

    // Counter saturation and squash counting (CNT_W = 2).
    drv(1'b1, AL, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0);
    repeat (5) step();
`ifdef COND_STATS_EN
    chk("exec_sat", 8'(exec_cnt), 8'd3);
`endif
    drv(1'b1, EQ, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0);
    step();
`ifdef COND_STATS_EN
    chk("squash_one", 8'(squash_cnt), 8'd1);
`endif
    drv(1'b1, AL, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    step();
    do_reset();
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Condition-check and flag-writeback stage that sits directly downstream of the 32-bit ALU.
- Consumes the ALU's NZCV flags (bit order {N,Z,C,V}) together with the instruction's 4-bit condition field and write controls.
- Holds the architectural NZCV flag register and evaluates the condition against it.
- Issues gated register, memory and PC write enables through a one-entry valid/ready output register.

Parameters:
- FLAGS_RST, 4'b0000, reset value of the NZCV register ({N,Z,C,V}).
- CNT_W, 16, width of the statistics counters (used only with COND_STATS_EN).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream instruction/flags valid.
- in_ready  out  1  stage can accept this cycle.
- in_cond  in  4  ARM condition field.
- in_flagw  in  2  flag write mask: [1] updates N,Z; [0] updates C,V.
- in_aluflags  in  4  {N,Z,C,V} from the ALU for this instruction.
- in_regw  in  1  register write request.
- in_memw  in  1  memory write request.
- in_pcs  in  1  PC write request.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_regw  out  1  in_regw AND condex (registered).
- out_memw  out  1  in_memw AND condex (registered).
- out_pcs  out  1  in_pcs AND condex (registered).
- out_condex  out  1  registered condition result.
- out_undef  out  1  registered: in_cond was 4'hF.
- flags  out  4  current architectural NZCV register.

Behaviour:
- Reset (async, rst_n=0):
  - flags=FLAGS_RST.
  - out_valid, out_regw, out_memw, out_pcs, out_condex, out_undef all 0.
  - Counters cleared.
  - Reset asserted mid-transfer discards the held output entry; no partial flag update.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Output fields are stable while out_valid && !out_ready.
- On accept:
  - condex is evaluated combinationally from the current flags register (pre-update), never from in_aluflags.
  - Output register loads the gated enables, condex and undef; out_valid becomes 1.
- Flag update, at the accept edge only when condex=1:
  - in_flagw[1]: N,Z <= in_aluflags[3:2].
  - in_flagw[0]: C,V <= in_aluflags[1:0].
  - A squashed instruction (condex=0) never writes flags, whatever in_flagw says.
- Back-to-back: an instruction accepted at cycle t+1 sees the flags written by the one accepted at t. Latency is 1 cycle from accept to out_valid.
- Transfer without accept in the same cycle: out_valid goes to 0. Simultaneous transfer and accept: the new entry replaces the old one and out_valid stays 1.
- Condition table:
  - 0 EQ Z; 1 NE !Z.
  - 2 CS C; 3 CC !C.
  - 4 MI N; 5 PL !N.
  - 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z.
  - 10 GE N==V; 11 LT N!=V.
  - 12 GT !Z&(N==V); 13 LE Z|(N!=V).
  - 14 AL 1.
  - 15: condex=0 and out_undef=1.
- in_valid=0: no state change except the output transfer.

Optional Feature:
- Macro: COND_STATS_EN.
- When defined, add two ports:
  - exec_cnt out CNT_W: counts accepts with condex=1.
  - squash_cnt out CNT_W: counts accepts with condex=0, including cond=4'hF.
- Both counters saturate at all-ones and are cleared by rst_n.
- When not defined, the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package cond_pkg:
  - cond_e enum (EQ..AL, NV=4'hF).
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - flagw bit constants FW_NZ=1, FW_CV=0.
- Sub-module cond_eval: purely combinational, inputs (cond, flags), outputs (condex, undef). It is instantiated once inside cond_unit.

Test Plan:
1. Reset: rst_n=0 with FLAGS_RST=4'b0000 -> flags=0, out_valid=0, in_ready=1; release, idle 3 cycles -> unchanged.
2. cond=EQ, flags Z=0, flagw=2'b11, aluflags=4'b0100, regw=1 -> out_condex=0, out_regw=0, flags stay 0000. Then cond=AL with the same inputs -> out_regw=1, flags=0100.
3. Back-to-back: AL with flagw=2'b11, aluflags=4'b0010 (C=1), then HI next cycle -> HI sees C=1,Z=0, so out_condex=1. Then LS -> out_condex=0.
4. Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs held, flags unchanged. Raise out_ready -> next entry is accepted the same cycle and out_valid stays 1.
5. Partial mask: flags=1111, AL with flagw=2'b01, aluflags=0000 -> flags=1100. Then cond=4'hF with regw=1 -> out_undef=1, out_regw=0, flags unchanged.
6. COND_STATS_EN with CNT_W=2: 5 AL accepts -> exec_cnt saturates at 3. 1 EQ accept with Z=0 -> squash_cnt=1. Assert rst_n mid-stream -> both counters 0.
